// File: rtl/mips32_mem_arb.sv
// Single-port memory arbiter for the MIPS32 core: shares one synchronous-read memory
// between instruction fetch (ip), data (dp) and a debug loader (ld) gated by cpu_halted.
module mips32_mem_arb #(
  parameter int AW         = 9,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_halted,
  input  logic          ip_req,
  input  logic          dp_req,
  input  logic          ld_req,
  input  logic          dp_we,
  input  logic          ld_we,
  input  logic [AW-1:0] ip_addr,
  input  logic [AW-1:0] dp_addr,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] dp_wdata,
  input  logic [DW-1:0] ld_wdata,
  output logic          ip_gnt,
  output logic          dp_gnt,
  output logic          ld_gnt,
  output logic          ip_rvalid,
  output logic          dp_rvalid,
  output logic          ld_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    arb_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } arb_state_t;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;

  // Grants are held off while rst is high so nothing touches memory during reset.
  always_comb begin
    ip_gnt = 1'b0;
    dp_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (dp_req && (!ip_req || (starve_cnt < SMAX))) dp_gnt = 1'b1;
          else if (ip_req)                                ip_gnt = 1'b1;
        end
        LOAD:    ld_gnt = ld_req;
        default: ;
      endcase
    end
  end

  assign mem_en = ip_gnt | dp_gnt | ld_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ip_gnt) begin
      mem_addr = ip_addr;
    end else if (dp_gnt) begin
      mem_we    = dp_we;
      mem_addr  = dp_addr;
      mem_wdata = dp_wdata;
    end else if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign rdata     = mem_rdata;
  assign arb_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      starve_cnt <= '0;
      ip_rvalid  <= 1'b0;
      dp_rvalid  <= 1'b0;
      ld_rvalid  <= 1'b0;
    end else begin
      ip_rvalid <= ip_gnt;
      dp_rvalid <= dp_gnt & ~dp_we;
      ld_rvalid <= ld_gnt & ~ld_we;

      unique case (state)
        RUN: begin
          if (ip_gnt)                               starve_cnt <= '0;
          else if (ip_req && (starve_cnt < SMAX))   starve_cnt <= starve_cnt + 1'b1;
          if (cpu_halted) state <= DRAIN;
        end
        DRAIN: state <= LOAD;
        LOAD:  if (!cpu_halted && !ld_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_arb.sv
// Directed self-checking bench for mips32_mem_arb with a behavioural sync-read memory.
module tb_mips32_mem_arb;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_halted;
  logic          ip_req, dp_req, ld_req;
  logic          dp_we, ld_we;
  logic [AW-1:0] ip_addr, dp_addr, ld_addr;
  logic [DW-1:0] dp_wdata, ld_wdata;
  logic          ip_gnt, dp_gnt, ld_gnt;
  logic          ip_rvalid, dp_rvalid, ld_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    arb_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  mips32_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .cpu_halted(cpu_halted),
    .ip_req(ip_req), .dp_req(dp_req), .ld_req(ld_req),
    .dp_we(dp_we), .ld_we(ld_we),
    .ip_addr(ip_addr), .dp_addr(dp_addr), .ld_addr(ld_addr),
    .dp_wdata(dp_wdata), .ld_wdata(ld_wdata),
    .ip_gnt(ip_gnt), .dp_gnt(dp_gnt), .ld_gnt(ld_gnt),
    .ip_rvalid(ip_rvalid), .dp_rvalid(dp_rvalid), .ld_rvalid(ld_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Inputs change at the falling edge; checks run 2ns later, well before the next rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle(); #2;
    checks++; if ({ip_gnt, dp_gnt, ld_gnt} !== 3'b000) begin errors++; $display("FAIL rst_gnts: got %b expected 000", {ip_gnt, dp_gnt, ld_gnt}); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL rst_mem: got en=%b we=%b addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    checks++; if ({ip_rvalid, dp_rvalid, ld_rvalid} !== 3'b000) begin errors++; $display("FAIL rst_rvalid: got %b expected 000", {ip_rvalid, dp_rvalid, ld_rvalid}); end
    checks++; if (arb_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", arb_state); end
    rst = 1'b0;
    next_cycle();
    ip_req = 1'b1; ip_addr = 9'd7; #2;
    checks++; if (ip_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 1", ip_gnt); end
    #1 rst = 1'b1; #1;
    checks++; if ({ip_gnt, dp_gnt, ld_gnt, mem_en} !== 4'b0000) begin errors++; $display("FAIL rst_mid_gnt_off: got %b expected 0000", {ip_gnt, dp_gnt, ld_gnt, mem_en}); end
    next_cycle(); #2;
    checks++; if (ip_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got %b expected 0", ip_rvalid); end
    checks++; if (arb_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", arb_state); end
    rst = 1'b0; ip_req = 1'b0;
    next_cycle(); #2;
    checks++; if ({ip_rvalid, dp_rvalid, ld_rvalid} !== 3'b000) begin errors++; $display("FAIL rst_after_rvalid: got %b expected 000", {ip_rvalid, dp_rvalid, ld_rvalid}); end
  endtask

  task automatic test_priority();
    logic [2:0] exp_gnt;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (c == 0) begin ip_req = 1'b1; dp_req = 1'b1; dp_we = 1'b0; ip_addr = 9'd1; dp_addr = 9'd2; end
      if (c == 5) begin ip_req = 1'b0; dp_req = 1'b0; end
      #2;
      // dp x3, ip once starve count hits 3, then dp again because the count cleared
      exp_gnt = (c == 3) ? 3'b100 : (c == 5) ? 3'b000 : 3'b010;
      checks++; if ({ip_gnt, dp_gnt, ld_gnt} !== exp_gnt) begin errors++; $display("FAIL prio_gnt c%0d: got %b expected %b", c, {ip_gnt, dp_gnt, ld_gnt}, exp_gnt); end
      checks++; if (dp_rvalid !== ((c >= 1 && c <= 3) || c == 5)) begin errors++; $display("FAIL prio_dp_rvalid c%0d: got %b", c, dp_rvalid); end
      checks++; if (ip_rvalid !== (c == 4)) begin errors++; $display("FAIL prio_ip_rvalid c%0d: got %b", c, ip_rvalid); end
    end
  endtask

  task automatic test_reads();
    next_cycle();
    dp_req = 1'b1; dp_we = 1'b1; dp_addr = 9'd5; dp_wdata = 32'hDEADBEEF; #2;
    checks++; if ({dp_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_write: got gnt=%b we=%b addr=%0d wdata=%h expected 1 1 5 deadbeef", dp_gnt, mem_we, mem_addr, mem_wdata); end
    next_cycle();
    dp_req = 1'b0; dp_we = 1'b0; ip_req = 1'b1; ip_addr = 9'd5; #2;
    checks++; if ({ip_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 9'd5}) begin errors++; $display("FAIL rd_ip_gnt: got gnt=%b we=%b addr=%0d expected 1 0 5", ip_gnt, mem_we, mem_addr); end
    checks++; if ({ip_rvalid, dp_rvalid, ld_rvalid} !== 3'b000) begin errors++; $display("FAIL rd_write_no_rvalid: got %b expected 000", {ip_rvalid, dp_rvalid, ld_rvalid}); end
    next_cycle();
    ip_req = 1'b0; #2;
    checks++; if ({ip_rvalid, rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_ip_data: got rvalid=%b rdata=%h expected 1 deadbeef", ip_rvalid, rdata); end
  endtask

  task automatic test_halt();
    next_cycle();
    ip_req = 1'b1; ip_addr = 9'd5; cpu_halted = 1'b1; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9'd0; #2;
    checks++; if ({ip_gnt, dp_gnt, ld_gnt, arb_state} !== {3'b100, 2'd0}) begin errors++; $display("FAIL halt_edge: got gnt=%b state=%0d expected 100 0", {ip_gnt, dp_gnt, ld_gnt}, arb_state); end
    next_cycle();
    dp_req = 1'b1; #2;
    checks++; if ({ip_gnt, dp_gnt, ld_gnt, mem_en, arb_state} !== {4'b0000, 2'd1}) begin errors++; $display("FAIL halt_drain: got gnt/en=%b state=%0d expected 0000 1", {ip_gnt, dp_gnt, ld_gnt, mem_en}, arb_state); end
    checks++; if ({ip_rvalid, rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL halt_drain_rvalid: got rvalid=%b rdata=%h expected 1 deadbeef", ip_rvalid, rdata); end
    next_cycle(); #2;
    checks++; if ({ip_gnt, dp_gnt, ld_gnt, arb_state} !== {3'b001, 2'd2}) begin errors++; $display("FAIL halt_load: got gnt=%b state=%0d expected 001 2", {ip_gnt, dp_gnt, ld_gnt}, arb_state); end
    checks++; if (ip_rvalid !== 1'b0) begin errors++; $display("FAIL halt_load_ip_rvalid: got %b expected 0", ip_rvalid); end
  endtask

  task automatic test_loader();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ld_we = 1'b1; ld_addr = 9'(i); ld_wdata = 32'h10 + 32'(i); #2;
      checks++; if ({ip_gnt, dp_gnt, ld_gnt, mem_we, mem_addr, mem_wdata} !== {3'b001, 1'b1, 9'(i), 32'h10 + 32'(i)}) begin errors++; $display("FAIL ld_write%0d: got gnt=%b we=%b addr=%0d wdata=%h", i, {ip_gnt, dp_gnt, ld_gnt}, mem_we, mem_addr, mem_wdata); end
    end
    next_cycle();
    ld_we = 1'b0; ld_addr = 9'd2; #2;
    checks++; if ({ld_gnt, mem_we, mem_addr, ld_rvalid} !== {1'b1, 1'b0, 9'd2, 1'b0}) begin errors++; $display("FAIL ld_read_gnt: got gnt=%b we=%b addr=%0d rvalid=%b expected 1 0 2 0", ld_gnt, mem_we, mem_addr, ld_rvalid); end
    next_cycle();
    cpu_halted = 1'b0; #2;
    checks++; if ({ld_rvalid, rdata} !== {1'b1, 32'h12}) begin errors++; $display("FAIL ld_read_data: got rvalid=%b rdata=%h expected 1 00000012", ld_rvalid, rdata); end
    next_cycle(); #2;
    checks++; if ({arb_state, ld_gnt, ip_gnt, dp_gnt} !== {2'd2, 3'b100}) begin errors++; $display("FAIL ld_hold_state: got state=%0d gnt(l,i,d)=%b expected 2 100", arb_state, {ld_gnt, ip_gnt, dp_gnt}); end
    next_cycle();
    ld_req = 1'b0; dp_req = 1'b0; #2;
    checks++; if ({arb_state, ld_gnt, ip_gnt, dp_gnt} !== {2'd2, 3'b000}) begin errors++; $display("FAIL ld_exit_edge: got state=%0d gnt=%b expected 2 000", arb_state, {ld_gnt, ip_gnt, dp_gnt}); end
    next_cycle(); #2;
    checks++; if ({arb_state, ip_gnt, dp_gnt} !== {2'd0, 2'b10}) begin errors++; $display("FAIL ld_resume: got state=%0d gnt(i,d)=%b expected 0 10", arb_state, {ip_gnt, dp_gnt}); end
    next_cycle();
    ip_req = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      ld_req = (c >= 3); #2;
      checks++; if ({mem_en, ip_gnt, dp_gnt, ld_gnt} !== 4'b0000) begin errors++; $display("FAIL idle c%0d: got en/gnt=%b expected 0000", c, {mem_en, ip_gnt, dp_gnt, ld_gnt}); end
    end
    // starve count must still be 0: dp should win three times before ip gets in
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      ld_req = 1'b0; ip_req = 1'b1; dp_req = 1'b1; dp_we = 1'b0; #2;
      checks++; if ({ip_gnt, dp_gnt} !== ((c == 3) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL idle_starve c%0d: got gnt(i,d)=%b", c, {ip_gnt, dp_gnt}); end
    end
    next_cycle();
    ip_req = 1'b0; dp_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem_rdata = '0;
    rst = 1'b1; cpu_halted = 1'b0;
    ip_req = 1'b0; dp_req = 1'b0; ld_req = 1'b0;
    dp_we = 1'b0; ld_we = 1'b0;
    ip_addr = '0; dp_addr = '0; ld_addr = '0;
    dp_wdata = '0; ld_wdata = '0;

    test_reset();
    test_priority();
    test_reads();
    test_halt();
    test_loader();
    test_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arb.md
# mips32_mem_arb

Single-port memory arbiter for the MIPS32 core. It shares one synchronous-read memory between three requesters: the instruction-fetch port (ip), the data/MEM-stage port (dp) and a debug loader port (ld). In normal running, dp has priority over ip, with a starvation guard that periodically lets ip win. The loader gets exclusive access only while the core is halted.

## Interface
- AW, 9: memory word-address width (512 words).
- DW, 32: data width.
- STARVE_MAX, 3: number of consecutive denied ip cycles after which ip outranks dp; must be ≥1.
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_halted  in  1  core halted flag; it gates loader access.
- ip_req, dp_req, ld_req  in  1 each  access request; the requester holds it until its gnt is high.
- dp_we, ld_we  in  1 each  write enable (the ip port is read-only).
- ip_addr, dp_addr, ld_addr  in  AW each  word address.
- dp_wdata, ld_wdata  in  DW each  write data.
- ip_gnt, dp_gnt, ld_gnt  out  1 each  grant, combinational, one-hot or all zero.
- ip_rvalid, dp_rvalid, ld_rvalid  out  1 each  read data valid, registered.
- rdata  out  DW  read data, equal to mem_rdata; meaningful only when an rvalid is high.
- mem_en  out  1  memory access strobe (equals the OR of the grants).
- mem_we  out  1  write enable of the granted port.
- mem_addr  out  AW  address of the granted port.
- mem_wdata  out  DW  write data of the granted port.
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read.
- arb_state  out  2  current state: RUN=0, DRAIN=1, LOAD=2.

## Operation
**States and transitions** (registered; the grant logic uses the current state only):
- RUN → DRAIN when cpu_halted=1.
- DRAIN → LOAD unconditionally after 1 cycle.
- LOAD → RUN when cpu_halted=0 and ld_req=0.
- LOAD stays in LOAD while ld_req=1, even if cpu_halted=0.

**Grant rules**
- RUN: ld_gnt=0.
  - If dp_req=1 and (ip_req=0 or starve_cnt<STARVE_MAX), dp wins.
  - Otherwise, if ip_req=1, ip wins.
- DRAIN: all grants 0 and mem_en=0.
- LOAD: ld_gnt=ld_req; ip_gnt=dp_gnt=0.

**Memory mux**
- mem_we, mem_addr and mem_wdata come from the granted port.
- With no grant, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
- ip access always drives mem_we=0.

**Starvation counter** (starve_cnt, width clog2(STARVE_MAX+1)):
- In RUN, increments each cycle with ip_req=1 and ip_gnt=0, saturating at STARVE_MAX.
- Clears to 0 on ip_gnt=1.
- Holds its value in DRAIN and LOAD.

**Read return**
- On a grant with we=0, the matching *_rvalid is high for exactly the next cycle.
- Writes produce no rvalid.
- At most one rvalid is high per cycle.

**Boundary behaviour**
- If cpu_halted rises in a cycle where state=RUN, RUN grants still occur that cycle. The read returns during DRAIN, so no read is outstanding on entry to LOAD.
- If a request drops without a grant, that is legal; no state is retained for it.
- If rst is asserted mid-operation, pending rvalids are killed immediately and no rvalid is emitted after reset.

**Reset values**
- arb_state=RUN, starve_cnt=0.
- All *_rvalid=0.
- With requests low, all grants and mem_* are 0.

## Timing
- Grant is combinational in the same cycle as the request; the memory is accessed at the same edge.
- Read latency is 1 cycle (grant at cycle n, rvalid and rdata at cycle n+1).
- Throughput is one access per cycle; back-to-back grants to the same port are allowed.
- Halt-to-loader latency: cpu_halted is sampled high at edge k, DRAIN is cycle k+1, and the earliest ld_gnt is cycle k+2.
- Resume: LOAD → RUN takes 1 edge after the exit condition holds; ip and dp can be granted in the following cycle.

## Test plan
- **Reset:** assert rst mid-read with ip_gnt=1 → ip_rvalid stays 0, arb_state=0, all grants 0 while rst=1.
- **Priority:** ip_req=dp_req=1 held for 4 cycles, STARVE_MAX=3.
  - Required: dp_gnt in cycles 0–2, ip_gnt in cycle 3, starve_cnt back to 0.
  - Also check dp_rvalid in cycles 1–3 and ip_rvalid in cycle 4.
- **Reads:** dp write addr 5 data 0xDEADBEEF, then an ip read of addr 5 → ip_rvalid one cycle after ip_gnt with rdata=0xDEADBEEF; no rvalid on the write.
- **Halt sequence:** ip read granted in the same cycle cpu_halted rises, with ld_req=1 held.
  - Required: ip_rvalid in the DRAIN cycle, ld_gnt first 2 cycles after the halt edge, ip_gnt=dp_gnt=0 throughout LOAD.
- **Loader:** ld writes addrs 0..3 with 0x10..0x13, then ld reads addr 2 → ld_rvalid with rdata=0x12.
  - Then drop cpu_halted while ld_req=1 → state stays LOAD.
  - Drop ld_req → RUN next cycle.
- **Idle and no-op:**
  - All requests low → mem_en=0 every cycle and starve_cnt stays 0.
  - ld_req=1 in RUN → ld_gnt stays 0.
